// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM plus ALU-op decoder; Moore strobes, except that PCEn in BRANCH follows zero.
// Outputs are combinational from the state and the IR fields; no backpressure, one state per clk.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] ALUcont,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ImmZero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal
);

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXECUTE = 4'd6;
  localparam logic [3:0] RWB     = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] IEXEC   = 4'd9;
  localparam logic [3:0] IWB     = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       mem_write_d;
  logic       ir_write_d;
  logic       reg_write_d;
  logic       pc_en_d;
  logic       illegal_d;
  logic [2:0] funct_alu;
  logic       funct_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    next_state  = FETCH;
    ALUcont     = ALU_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ImmZero     = 1'b0;
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    PCSrc       = 2'b00;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    reg_write_d = 1'b0;
    pc_en_d     = 1'b0;
    illegal_d   = 1'b0;
    case (state)
      FETCH: begin
        ir_write_d = 1'b1;
        ALUSrcB    = 2'b01;
        pc_en_d    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW:                      next_state = MEMADR;
          OP_R:                              next_state = EXECUTE;
          OP_BEQ, OP_BNE:                    next_state = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = IEXEC;
          OP_J:                              next_state = JUMP;
          default:                           illegal_d  = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        reg_write_d = 1'b1;
        MemtoReg    = 1'b1;
      end
      MEMWR: begin
        IorD        = 1'b1;
        mem_write_d = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUcont    = funct_alu;
        illegal_d  = ~funct_ok;
        next_state = funct_ok ? RWB : FETCH;
      end
      RWB: begin
        reg_write_d = 1'b1;
        RegDst      = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUcont = ALU_SUB;
        PCSrc   = 2'b01;
        // bne is the only opcode reaching here besides beq
        pc_en_d = (op == OP_BNE) ? ~zero : zero;
      end
      IEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = IWB;
        case (op)
          OP_ANDI: begin ALUcont = ALU_AND; ImmZero = 1'b1; end
          OP_ORI:  begin ALUcont = ALU_OR;  ImmZero = 1'b1; end
          OP_SLTI: ALUcont = ALU_SLT;
          default: ALUcont = ALU_ADD;
        endcase
      end
      IWB: reg_write_d = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        pc_en_d = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Reset masks every strobe that could corrupt architectural state.
  assign MemWrite = mem_write_d & ~reset;
  assign IRWrite  = ir_write_d  & ~reset;
  assign RegWrite = reg_write_d & ~reset;
  assign PCEn     = pc_en_d     & ~reset;
  assign illegal  = illegal_d   & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, reset corner cases, and random
// instruction streams checked against a per-instruction cycle model.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       immz;
    logic       iord;
    logic       mw;
    logic       irw;
    logic       regdst;
    logic       m2r;
    logic       rw;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       ill;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cpi;
    int         chk;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] ALUcont;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ImmZero, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic [1:0] PCSrc;
  logic       PCEn, illegal;
  outs_t      act;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];
  logic [5:0] op_list [0:9];
  logic [5:0] fn_list [0:4];

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .ALUcont(ALUcont), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmZero(ImmZero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCSrc(PCSrc), .PCEn(PCEn),
    .illegal(illegal)
  );

  assign act = {ALUcont, ALUSrcA, ALUSrcB, ImmZero, IorD, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, PCSrc, PCEn, illegal};

  function automatic outs_t base();
    outs_t e;
    e = '0;
    e.alu = 3'b010;
    return e;
  endfunction

  function automatic outs_t fetch_exp();
    outs_t e;
    e = base();
    e.irw = 1'b1; e.srcb = 2'b01; e.pcen = 1'b1;
    return e;
  endfunction

  function automatic outs_t mask_rst(outs_t e);
    outs_t m;
    m = e;
    m.mw = 1'b0; m.irw = 1'b0; m.rw = 1'b0; m.pcen = 1'b0; m.ill = 1'b0;
    return m;
  endfunction

  // {legal, alu code} of an R-type funct
  function automatic logic [3:0] r_alu(logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit is_imm(logic [5:0] o);
    return o == 6'b001000 || o == 6'b001100 || o == 6'b001101 || o == 6'b001010;
  endfunction

  function automatic bit is_br(logic [5:0] o);
    return o == 6'b000100 || o == 6'b000101;
  endfunction

  function automatic bit legal_op(logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || is_br(o) || is_imm(o) || o == 6'b000010;
  endfunction

  function automatic int model_cpi(logic [5:0] o, logic [5:0] f);
    logic [3:0] ra;
    ra = r_alu(f);
    if (!legal_op(o)) return 2;
    if (o == 6'b000000) return ra[3] ? 4 : 3;
    if (o == 6'b100011) return 5;
    if (is_br(o) || o == 6'b000010) return 3;
    return 4;
  endfunction

  // Expected outputs for step k (0 = FETCH) of instruction o/f, with this cycle's zero.
  function automatic outs_t model_out(logic [5:0] o, logic [5:0] f, logic z, int k);
    outs_t e;
    logic [3:0] ra;
    ra = r_alu(f);
    e = base();
    if (k == 0) return fetch_exp();
    if (k == 1) begin
      e.srcb = 2'b11; e.ill = !legal_op(o);
      return e;
    end
    if (o == 6'b000000) begin
      if (k == 2) begin e.srca = 1'b1; e.alu = ra[2:0]; e.ill = !ra[3]; end
      else begin e.rw = 1'b1; e.regdst = 1'b1; end
    end else if (o == 6'b100011 || o == 6'b101011) begin
      if (k == 2) begin e.srca = 1'b1; e.srcb = 2'b10; end
      else if (k == 3) begin e.iord = 1'b1; e.mw = (o == 6'b101011); end
      else begin e.rw = 1'b1; e.m2r = 1'b1; end
    end else if (is_br(o)) begin
      e.srca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01;
      e.pcen = (o == 6'b000100) ? z : ~z;
    end else if (is_imm(o)) begin
      if (k == 2) begin
        e.srca = 1'b1; e.srcb = 2'b10;
        case (o)
          6'b001100: begin e.alu = 3'b000; e.immz = 1'b1; end
          6'b001101: begin e.alu = 3'b001; e.immz = 1'b1; end
          6'b001010: e.alu = 3'b111;
          default:   e.alu = 3'b010;
        endcase
      end else e.rw = 1'b1;
    end else begin
      e.pcsrc = 2'b10; e.pcen = 1'b1;
    end
    return e;
  endfunction

  task automatic check(string name, int k, outs_t a, outs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s step%0d: got %b required %b", name, k, a, e);
    end
  endtask

  task automatic add(string name, logic [5:0] o, logic [5:0] f, logic z, int cpi, int chk, outs_t e);
    vec_t v;
    v.name = name; v.op = o; v.funct = f; v.zero = z; v.cpi = cpi; v.chk = chk; v.exp = e;
    vecs.push_back(v);
  endtask

  // Entry and exit: 2 time units after a posedge, in a FETCH cycle.
  task automatic run_vec(vec_t v);
    for (int k = 0; k < v.cpi; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      op = v.op; funct = v.funct; zero = v.zero; #1;
      if (k == v.chk) check(v.name, k, act, v.exp);
    end
    @(posedge clk); #2;
    check({v.name, "_next_fetch"}, v.cpi, act, fetch_exp());
  endtask

  task automatic run_instr(logic [5:0] o, logic [5:0] f, int rst_at);
    int cpi;
    logic z;
    cpi = model_cpi(o, f);
    for (int k = 0; k < cpi; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      z = 1'($urandom_range(0, 1));
      op = o; funct = f; zero = z;
      if (k == rst_at) begin
        reset = 1'b1; #1;
        check("rand_rst", k, act, mask_rst(model_out(o, f, z, k)));
        @(posedge clk); #1; reset = 1'b0; #1;
        return;
      end
      #1;
      check("rand", k, act, model_out(o, f, z, k));
    end
    @(posedge clk); #2;
  endtask

  initial begin
    outs_t e;
    op_list = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
    fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    e = base(); e.srcb = 2'b11;                               add("lw_decode", 6'b100011, 6'h00, 1'b0, 5, 1, e);
    e = base(); e.srca = 1; e.srcb = 2'b10;                   add("lw_memadr", 6'b100011, 6'h00, 1'b0, 5, 2, e);
    e = base(); e.iord = 1;                                   add("lw_memrd", 6'b100011, 6'h00, 1'b0, 5, 3, e);
    e = base(); e.rw = 1; e.m2r = 1;                          add("lw_memwb", 6'b100011, 6'h00, 1'b0, 5, 4, e);
    e = base(); e.iord = 1; e.mw = 1;                         add("sw_memwr", 6'b101011, 6'h00, 1'b0, 4, 3, e);
    e = base(); e.srca = 1; e.alu = 3'b110;                   add("r_sub", 6'b000000, 6'b100010, 1'b0, 4, 2, e);
    e = base(); e.srca = 1; e.alu = 3'b111;                   add("r_slt", 6'b000000, 6'b101010, 1'b0, 4, 2, e);
    e = base(); e.srca = 1; e.alu = 3'b001;                   add("r_or", 6'b000000, 6'b100101, 1'b0, 4, 2, e);
    e = base(); e.rw = 1; e.regdst = 1;                       add("r_or_wb", 6'b000000, 6'b100101, 1'b0, 4, 3, e);
    e = base(); e.srca = 1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = 1;
    add("beq_z1", 6'b000100, 6'h00, 1'b1, 3, 2, e);
    add("bne_z0", 6'b000101, 6'h00, 1'b0, 3, 2, e);
    e.pcen = 0;
    add("beq_z0", 6'b000100, 6'h00, 1'b0, 3, 2, e);
    add("bne_z1", 6'b000101, 6'h00, 1'b1, 3, 2, e);
    e = base(); e.srca = 1; e.srcb = 2'b10; e.alu = 3'b000; e.immz = 1;
    add("andi_iexec", 6'b001100, 6'h00, 1'b0, 4, 2, e);
    e = base(); e.srca = 1; e.srcb = 2'b10; e.alu = 3'b111;   add("slti_iexec", 6'b001010, 6'h00, 1'b0, 4, 2, e);
    e = base(); e.rw = 1;                                     add("slti_iwb", 6'b001010, 6'h00, 1'b0, 4, 3, e);
    e = base(); e.srcb = 2'b11; e.ill = 1;                    add("bad_op", 6'b111111, 6'h00, 1'b0, 2, 1, e);
    e = base(); e.srca = 1; e.ill = 1;                        add("bad_funct", 6'b000000, 6'b000111, 1'b0, 3, 2, e);
    e = base(); e.pcsrc = 2'b10; e.pcen = 1;                  add("j_jump", 6'b000010, 6'h00, 1'b0, 3, 2, e);

    reset = 1'b1; op = 6'b101011; funct = 6'h00; zero = 1'b0;
    @(posedge clk); #2;
    check("reset_hold", 0, act, mask_rst(fetch_exp()));
    @(posedge clk); #1; reset = 1'b0; #1;
    check("reset_release", 0, act, fetch_exp());

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset landing in MEMWR of a sw, held two cycles.
    op = 6'b101011;
    for (int k = 1; k <= 3; k++) begin @(posedge clk); #1; end
    reset = 1'b1; #1;
    e = base(); e.iord = 1;
    check("rst_in_memwr", 3, act, e);
    @(posedge clk); #2;
    check("rst_second_cycle", 0, act, mask_rst(fetch_exp()));
    @(posedge clk); #1; reset = 1'b0; #1;
    check("rst_fetch_after", 0, act, fetch_exp());

    for (int n = 0; n < 400; n++) begin
      logic [5:0] o, f;
      int rst_at;
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 9)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 4)];
      rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(o, f, rst_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
